// File: rtl/ram_rd_stream.sv
// ram_rd_stream: walks a contiguous RAM address range on command, aligns the
// 2-cycle-latency read data through a 3-stage issue-valid pipeline and hands
// the words downstream through a small credit-managed valid/ready FIFO.
module ram_rd_stream #(
  parameter int AW         = 16,
  parameter int DW         = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clock,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] rdaddress,
  input  logic [DW-1:0] q,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
);

  localparam int CW = AW + 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Pointer advance that also works for non-power-of-two depths.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PW'(FIFO_DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  state_t         state_q, state_d;
  logic [AW-1:0]  base_q, base_d;
  logic [CW-1:0]  len_q, len_d;
  logic [CW-1:0]  issued_q, issued_d;
  logic [CW-1:0]  popped_q, popped_d;
  logic [AW-1:0]  rdaddress_q, rdaddress_d;
  logic [2:0]     v_q, v_d;          // bit0 = v0 (address held), bit2 = v2 (q valid)
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           out_valid_q, out_valid_d;
  logic [DW-1:0]  fifo_mem_q [FIFO_DEPTH];
  logic [DW-1:0]  fifo_mem_d [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [NW-1:0]  fifo_cnt_q, fifo_cnt_d;

  logic           wr_s;
  logic           pop_s;
  logic           issue_s;
  logic [31:0]    used_s;

  assign busy      = busy_q;
  assign done      = done_q;
  assign rdaddress = rdaddress_q;
  assign out_valid = out_valid_q;
  assign out_data  = fifo_mem_q[rd_ptr_q];

  // Credit accounting: a read may issue only if its word is guaranteed a FIFO slot.
  always_comb begin
    wr_s    = v_q[2];
    pop_s   = out_valid_q & out_ready;
    used_s  = 32'(fifo_cnt_q) + 32'(v_q[0]) + 32'(v_q[1]) + 32'(v_q[2]);
    issue_s = (state_q == ST_RUN) && (issued_q < len_q) && (used_s < 32'(FIFO_DEPTH));
  end

  // Output FIFO next state: write the aligned RAM word, pop on handshake.
  always_comb begin
    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (wr_s) begin
      fifo_mem_d[wr_ptr_q] = q;
      wr_ptr_d             = next_ptr(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = next_ptr(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    fifo_cnt_d  = fifo_cnt_q + NW'(wr_s) - NW'(pop_s);
    out_valid_d = (fifo_cnt_d != {NW{1'b0}});
  end

  // Sequencer next state: command capture, read issue, completion tracking.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    issued_d    = issued_q;
    popped_d    = popped_q;
    rdaddress_d = rdaddress_q;
    v_d         = {v_q[1], v_q[0], 1'b0};
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len != {AW{1'b0}}) begin
            // The first read goes out on the accepting edge so that
            // rdaddress=base is already presented in the next cycle.
            state_d     = ST_RUN;
            base_d      = base_addr;
            len_d       = {1'b0, len};
            popped_d    = {CW{1'b0}};
            rdaddress_d = base_addr;
            v_d[0]      = 1'b1;
            issued_d    = CW'(1);
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (issue_s) begin
          rdaddress_d = base_q + issued_q[AW-1:0];
          v_d[0]      = 1'b1;
          issued_d    = issued_q + CW'(1);
        end else begin
          rdaddress_d = rdaddress_q;
        end
        if (pop_s) begin
          popped_d = popped_q + CW'(1);
          if (popped_d == len_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State register; reset clears the issue pipeline so returning data is dropped.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      base_q      <= {AW{1'b0}};
      len_q       <= {CW{1'b0}};
      issued_q    <= {CW{1'b0}};
      popped_q    <= {CW{1'b0}};
      rdaddress_q <= {AW{1'b0}};
      v_q         <= 3'b000;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      wr_ptr_q    <= {PW{1'b0}};
      rd_ptr_q    <= {PW{1'b0}};
      fifo_cnt_q  <= {NW{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= {DW{1'b0}};
      end
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      popped_q    <= popped_d;
      rdaddress_q <= rdaddress_d;
      v_q         <= v_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_cnt_q  <= fifo_cnt_d;
      fifo_mem_q  <= fifo_mem_d;
    end
  end

endmodule

// File: tb/tb_ram_rd_stream.sv
// tb_ram_rd_stream: drives commands and downstream backpressure against a
// behavioural 2-cycle RAM; expected words come from the address-order rule.
module tb_ram_rd_stream;

  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clock = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] len;
  logic          busy;
  logic          done;
  logic [AW-1:0] rdaddress;
  logic [DW-1:0] q;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] ram_p1;

  int n_checks = 0;
  int n_errors = 0;

  ram_rd_stream #(.AW(AW), .DW(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clock     (clock),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .rdaddress (rdaddress),
    .q         (q),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clock = ~clock;

  // RAM contents: mem[a] = a + 100.
  function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
    return 32'(a) + 32'd100;
  endfunction

  // Two-cycle registered-read RAM model.
  always @(posedge clock) begin
    ram_p1 <= mem_f(rdaddress);
    q      <= ram_p1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode 0: ready high; 1: 1,0,0,1 pattern; 2: random; 3: stalled through cycle 20
  function automatic logic ready_for(input int mode, input int cyc);
    case (mode)
      0: return 1'b1;
      1: return ((cyc % 4) == 0) || ((cyc % 4) == 3);
      2: return ($urandom_range(0, 3) != 0);
      3: return (cyc > 20);
      default: return 1'b1;
    endcase
  endfunction

  // Issue one command (entered just after a rising edge) and follow it to completion.
  task automatic run_cmd(input logic [AW-1:0] b, input logic [AW-1:0] n, input int mode,
                         input bit chk_lat, input int rst_after);
    logic [DW-1:0] expq[$];
    int            pops = 0;
    int            last_pop = 0;
    int            cyc;
    int            budget;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [AW-1:0] addr0;
    logic          exp_done;
    logic          exp_busy;
    bit            fin = 1'b0;
    bit            did_rst = 1'b0;

    for (int i = 0; i < int'(n); i++) expq.push_back(mem_f(b + AW'(i)));
    addr0  = rdaddress;
    budget = int'(n) * 8 + 60;

    start     = 1'b1;
    base_addr = b;
    len       = n;
    out_ready = ready_for(mode, 0);
    @(posedge clock); #1;
    start     = 1'b0;
    base_addr = AW'($urandom);
    len       = AW'($urandom);
    cyc = 1;
    while (!fin && cyc < budget) begin
      out_ready = ready_for(mode, cyc);
      // random starts while busy/done must be ignored
      if (mode == 2 && !(pops == int'(n) && cyc == last_pop + 2)) start = 1'($urandom);
      else start = 1'b0;
      @(negedge clock);
      if (chk_lat && cyc == 1) check_eq("lat_addr", rdaddress, b);
      if (chk_lat && cyc <= 3) check_eq("lat_novalid", out_valid, 1'b0);
      if (chk_lat && cyc == 4) begin
        check_eq("lat_valid", out_valid, 1'b1);
        check_eq("lat_data", out_data, mem_f(b));
      end
      if (n == '0) check_eq("len0_addr", rdaddress, addr0);
      if (mode == 3 && (cyc == 10 || cyc == 20)) check_eq("stall_addr", rdaddress, b + AW'(DEPTH - 1));
      check_eq("fifo_bound", 64'(dut.fifo_cnt_q <= DEPTH), 64'd1);
      if (prev_stall) begin
        check_eq("stall_valid", out_valid, 1'b1);
        check_eq("stall_data", out_data, prev_data);
      end
      exp_done = (pops == int'(n)) && (cyc == last_pop + 1);
      exp_busy = (n != '0) && ((pops < int'(n)) || (cyc <= last_pop));
      check_eq("done", done, exp_done);
      check_eq("busy", busy, exp_busy);
      if (out_valid && out_ready) begin
        if (expq.size() == 0) check_eq("extra_word", 64'(pops + 1), 64'(n));
        else check_eq("data", out_data, expq.pop_front());
        pops++;
        last_pop = cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (pops == int'(n) && cyc == last_pop + 2) fin = 1'b1;
      if (rst_after > 0 && pops == rst_after) begin
        #2 rst = 1'b1;
        #1;
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_valid", out_valid, 1'b0);
        check_eq("rst_addr", rdaddress, '0);
        @(posedge clock); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
          @(negedge clock);
          check_eq("post_rst_valid", out_valid, 1'b0);
          check_eq("post_rst_busy", busy, 1'b0);
          @(posedge clock); #1;
        end
        fin     = 1'b1;
        did_rst = 1'b1;
      end
      if (!fin) begin
        @(posedge clock); #1;
        cyc++;
      end
    end
    start = 1'b0;
    check_eq("finished", fin, 1'b1);
    if (!did_rst) begin
      @(posedge clock); #1;
    end
  endtask

  initial begin
    logic [AW-1:0] rb;
    logic [AW-1:0] rn;
    int            rm;

    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    len       = '0;
    out_ready = 1'b0;
    @(negedge clock);
    check_eq("reset_busy", busy, 1'b0);
    check_eq("reset_done", done, 1'b0);
    check_eq("reset_valid", out_valid, 1'b0);
    check_eq("reset_addr", rdaddress, '0);
    @(posedge clock); #1;
    rst = 1'b0;
    @(posedge clock); #1;

    run_cmd(16'd100, 16'd0, 0, 1'b0, 0);      // zero length
    run_cmd(16'd8, 16'd5, 0, 1'b1, 0);        // basic stream
    run_cmd(16'd200, 16'd16, 1, 1'b0, 0);     // periodic backpressure
    run_cmd(16'd300, 16'd10, 3, 1'b0, 0);     // full stall
    run_cmd(16'hFFFE, 16'd4, 0, 1'b1, 0);     // address wrap
    run_cmd(16'd500, 16'd8, 0, 1'b0, 3);      // reset mid-run
    run_cmd(16'd0, 16'd2, 0, 1'b1, 0);        // clean restart

    for (int t = 0; t < 12; t++) begin
      rb = AW'($urandom);
      rn = AW'($urandom_range(0, 20));
      rm = $urandom_range(0, 2);
      run_cmd(rb, rn, rm, (rn != '0), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
